uart_tx_serializer: RTL and testbench

UART transmit serializer, the transmit end of the demo's serial link. It accepts a parallel byte over a valid/ready handshake and drives the frame onto the TX pin. The frame is one start bit, the data bits LSB-first, an optional parity bit, then 1 or 2 stop bits. Its output transitions are the ones the receive-side pin-change detector and receiver consume in loopback.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx_serializer.sv | 150 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the frame state encoding, parity codes and the bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per bit, truncated toward zero.
    function automatic int clks_per_bit(
        input int clk_freq,
        input int baud
    );
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with a one-cycle bit_end strobe.
// Ports: clk_i, rst_ni (sync, active low), restart_i, bit_end_o.
module uart_baud_gen #(
    parameter int CPB = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Restart lines the count up with the first start-bit cycle.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter, start/data(LSB first)/parity/stop.
// Ports: clk, rst (sync, active low), tx_data/tx_valid/tx_ready in,
//        tx_pin (registered, idle high), tx_busy, tx_done (1-cycle pulse).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_pin,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int IW  = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    if (CPB < 2) begin : g_cpb_chk
        $error("uart_tx_serializer: CLK_FREQ/BAUD below 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
        $error("uart_tx_serializer: DATA_BITS out of 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_par_chk
        $error("uart_tx_serializer: bad PARITY");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("uart_tx_serializer: STOP_BITS not 1 or 2");
    end

    uart_state_e          state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 pin_q, pin_d;
    logic                 bit_end;
    logic                 restart;
    logic                 last_stop;
    logic                 ready;
    logic                 par_bit;
    logic                 dbit;

    uart_baud_gen #(
        .CPB(CPB)
    ) u_baud (
        .clk_i    (clk),
        .rst_ni   (rst),
        .restart_i(restart),
        .bit_end_o(bit_end)
    );

    // Odd parity: data ones + parity bit is odd.
    assign par_bit = (PARITY == PAR_ODD) ? ~(^data_q) : (^data_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        restart   = 1'b0;
        last_stop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = '0;
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ?
                                  ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        idx_d     = '0;
                        last_stop = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        // Accepting in the final stop cycle chains frames with no gap.
        ready = (state_q == ST_IDLE) || last_stop;
        if (ready && tx_valid) begin
            state_d = ST_START;
            data_d  = tx_data;
            idx_d   = '0;
            restart = 1'b1;
        end

        dbit = 1'b1;
        for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_d == IW'(i)) dbit = data_d[i];
        end

        // The pin is registered from the next state so it is glitch-free.
        unique case (state_d)
            ST_START:  pin_d = 1'b0;
            ST_DATA:   pin_d = dbit;
            ST_PARITY: pin_d = par_bit;
            default:   pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            pin_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            pin_q   <= pin_d;
        end
    end

    assign tx_ready = ready;
    assign tx_done  = last_stop;
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_pin   = pin_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for the UART transmitter.
// Four instances (8N1, 8E1, 8O1, 8N2) share one monitor via a select.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [3:0] val_v, rdy_v, pin_v, busy_v, done_v;
    logic       rdy_m, pin_m, busy_m, done_m;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    bit   in_frame = 1'b0;
    bit   abort = 1'b0;
    exp_t sb[$];
    int   starts_q[$];
    int   par_of[4]  = '{0, 2, 1, 0};
    int   stop_of[4] = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done_m === 1'b1) done_cnt++;

    assign val_v = tx_valid ? (4'b0001 << sel) : 4'b0000;

    always_comb begin
        rdy_m  = rdy_v[sel];
        pin_m  = pin_v[sel];
        busy_m = busy_v[sel];
        done_m = done_v[sel];
    end

    uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .tx_data(tx_data),
        .tx_valid(val_v[0]), .tx_ready(rdy_v[0]),
        .tx_pin(pin_v[0]), .tx_busy(busy_v[0]),
        .tx_done(done_v[0]));

    uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .clk(clk), .rst(rst), .tx_data(tx_data),
        .tx_valid(val_v[1]), .tx_ready(rdy_v[1]),
        .tx_pin(pin_v[1]), .tx_busy(busy_v[1]),
        .tx_done(done_v[1]));

    uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100),
        .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o1 (
        .clk(clk), .rst(rst), .tx_data(tx_data),
        .tx_valid(val_v[2]), .tx_ready(rdy_v[2]),
        .tx_pin(pin_v[2]), .tx_busy(busy_v[2]),
        .tx_done(done_v[2]));

    uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .rst(rst), .tx_data(tx_data),
        .tx_valid(val_v[3]), .tx_ready(rdy_v[3]),
        .tx_pin(pin_v[3]), .tx_busy(busy_v[3]),
        .tx_done(done_v[3]));

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: start, LSB-first data, optional parity, stops.
    function automatic logic [15:0] frame_bits(input logic [7:0] d,
                                               input int par);
        logic [15:0] v;
        int ones;
        v = '1;
        ones = 0;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v[i+1] = d[i];
            ones += int'(d[i]);
        end
        if (par == 1) v[9] = (ones % 2 == 0);
        else if (par == 2) v[9] = (ones % 2 == 1);
        return v;
    endfunction

    task automatic watch_frame();
        int par, nbits, total, b, start_cyc;
        int unst, dn_bad, rd_bad, by_bad;
        bit last;
        exp_t it;
        logic [15:0] got, expv;
        par = par_of[sel];
        nbits = 9 + ((par != 0) ? 1 : 0) + stop_of[sel];
        total = nbits * CPB;
        unst = 0; dn_bad = 0; rd_bad = 0; by_bad = 0;
        got = '1;
        in_frame = 1'b1;
        start_cyc = cyc;
        if (sb.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            it.data = 8'h00;
            it.cyc = start_cyc - 1;
        end else begin
            it = sb.pop_front();
        end
        expv = frame_bits(it.data, par);
        for (int k = 0; k < total; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (abort) begin
                    abort = 1'b0;
                    check("abort_done", 32'(dn_bad), 32'd0);
                    in_frame = 1'b0;
                    return;
                end
            end
            b = k / CPB;
            if (k % CPB == 0) got[b] = pin_m;
            else if (pin_m !== got[b]) unst++;
            last = (k == total - 1);
            if (done_m !== last) dn_bad++;
            if (rdy_m !== last) rd_bad++;
            if (busy_m !== 1'b1) by_bad++;
        end
        starts_q.push_back(start_cyc);
        check("latency", 32'(start_cyc - it.cyc), 32'd1);
        check("frame_bits", 32'(got), 32'(expv));
        check("byte", 32'(got[8:1]), 32'(it.data));
        check("bit_stable", 32'(unst), 32'd0);
        check("done_timing", 32'(dn_bad), 32'd0);
        check("ready_timing", 32'(rd_bad), 32'd0);
        check("busy_span", 32'(by_bad), 32'd0);
        in_frame = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst && pin_m === 1'b0) watch_frame();
        end
    end

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send(input logic [7:0] d, input bit hold);
        int n;
        exp_t it;
        n = 0;
        tx_data = d;
        tx_valid = 1'b1;
        #1;
        while (rdy_m !== 1'b1 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("accept_timeout", 32'(rdy_m), 32'd1);
        it.data = d;
        it.cyc = cyc;
        sb.push_back(it);
        @(posedge clk); #2;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || in_frame) && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        check("idle_timeout",
              32'((sb.size() != 0 || in_frame) ? 1 : 0), 32'd0);
        @(posedge clk); #2;
    endtask

    initial begin
        int d0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pin", 32'(pin_m), 32'd1);
        check("rst_ready", 32'(rdy_m), 32'd1);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_done", 32'(done_m), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;

        send(8'h55, 1'b0);
        wait_idle();

        d0 = done_cnt;
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b0);
        wait_idle();
        check("b2b_gap",
              32'(starts_q[$] - starts_q[$-1]), 32'd40);
        check("b2b_dones", 32'(done_cnt - d0), 32'd2);

        sel = 2'd1;
        @(posedge clk); #2;
        send(8'h07, 1'b0);
        wait_idle();

        sel = 2'd2;
        @(posedge clk); #2;
        send(8'h07, 1'b0);
        wait_idle();

        sel = 2'd3;
        @(posedge clk); #2;
        send(8'hFF, 1'b0);
        wait_idle();

        sel = 2'd0;
        @(posedge clk); #2;
        send(8'hC3, 1'b0);
        tx_data = 8'h00;
        wait_idle();

        // Abort inside data bit 3 (frame cycles 17..20).
        send(8'hF0, 1'b0);
        repeat (17) begin
            @(posedge clk); #2;
        end
        d0 = done_cnt;
        abort = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_pin", 32'(pin_m), 32'd1);
        check("mid_rst_ready", 32'(rdy_m), 32'd1);
        check("mid_rst_busy", 32'(busy_m), 32'd0);
        check("mid_rst_done", 32'(done_m), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (8) begin
            @(posedge clk); #2;
        end
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_sb", 32'(sb.size()), 32'd0);
        send(8'h5A, 1'b0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
